// File: rtl/ring_counter_param.sv
// rtl/ring_counter_param.sv - WIDTH-bit one-hot ring / Johnson shift counter with wrap and illegal-state flags
// Optional RING_SELF_CORRECT_EN: an enabled shift from an illegal state reloads the seed instead.
module ring_counter_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             init,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             illegal
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] count_inv;
    logic [WIDTH-1:0] shift_val;
    logic             ring_legal;
    logic             johnson_legal;
    logic             illegal_c;

    // Ring restarts from bit 0; Johnson restarts from all zeros.
    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        return m ? '0 : WIDTH'(1);
    endfunction

    always_comb begin
        count_inv     = ~count_q;
        ring_legal    = (count_q != '0) &&
                        ((count_q & (count_q - WIDTH'(1))) == '0);
        // 0..01..1 has no set bit above a clear one; 1..10..0 is its complement.
        johnson_legal = ((count_q & (count_q + WIDTH'(1))) == '0) ||
                        ((count_inv & (count_inv + WIDTH'(1))) == '0);
        illegal_c     = mode_q ? !johnson_legal : !ring_legal;
    end

    always_comb begin
        shift_val = count_q;
        if (!dir) begin
            shift_val = {count_q[WIDTH-2:0], count_q[WIDTH-1] ^ mode_q};
        end else begin
            shift_val = {count_q[0] ^ mode_q, count_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        count_d = count_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        if (init) begin
            count_d = seed_of(mode);
            mode_d  = mode;
        end else if (load) begin
            count_d = load_val;
            mode_d  = mode;
        end else if (mode != mode_q) begin
            count_d = seed_of(mode);
            mode_d  = mode;
        end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
            if (illegal_c) begin
                count_d = seed_of(mode_q);
            end else begin
                count_d = shift_val;
                wrap_d  = (shift_val == seed_of(mode_q));
            end
`else
            count_d = shift_val;
            wrap_d  = (shift_val == seed_of(mode_q));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            count_q <= seed_of(mode);
            mode_q  <= mode;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign illegal = illegal_c;

endmodule

// File: tb/tb_ring_counter_param.sv
// tb/tb_ring_counter_param.sv - directed self-checking bench for ring_counter_param (WIDTH=8)
module tb_ring_counter_param;

    localparam int WIDTH = 8;

    logic             clk;
    logic             init;
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             illegal;

    int checks;
    int errors;

    ring_counter_param #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .init     (init),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] c, input logic w, input logic il);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
        check({tag, ".illegal"}, 32'(illegal), 32'(il));
    endtask

    logic [7:0] ring_seq [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] john_seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

    initial begin
        checks   = 0;
        errors   = 0;
        init     = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = '0;

        tick();
        check_state("reset_ring", 8'h01, 1'b0, 1'b0);

        init = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_state($sformatf("ring_up[%0d]", i), ring_seq[i], (i == 7), 1'b0);
        end

        en = 1'b0;
        tick();
        check_state("ring_hold", 8'h01, 1'b0, 1'b0);

        en = 1'b1;
        tick();
        tick();
        check_state("ring_at_04", 8'h04, 1'b0, 1'b0);
        dir = 1'b1;
        tick();
        check_state("dir_dn0", 8'h02, 1'b0, 1'b0);
        tick();
        check_state("dir_dn1", 8'h01, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("dir_hold[%0d]", i), 8'h01, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick();
        check_state("ring_dn_rollover", 8'h80, 1'b0, 1'b0);

        en   = 1'b0;
        dir  = 1'b0;
        init = 1'b1;
        mode = 1'b1;
        tick();
        check_state("reset_johnson", 8'h00, 1'b0, 1'b0);
        init = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_state($sformatf("john_up[%0d]", i), john_seq[i], (i == 15), 1'b0);
        end
        dir = 1'b1;
        tick();
        check_state("john_dn0", 8'h80, 1'b0, 1'b0);
        tick();
        check_state("john_dn1", 8'hC0, 1'b0, 1'b0);

        mode     = 1'b0;
        dir      = 1'b0;
        init     = 1'b1;
        load     = 1'b1;
        load_val = 8'h10;
        en       = 1'b1;
        tick();
        check_state("prio_init", 8'h01, 1'b0, 1'b0);
        init = 1'b0;
        en   = 1'b0;
        tick();
        check_state("prio_load", 8'h10, 1'b0, 1'b0);
        load = 1'b0;
        mode = 1'b1;
        en   = 1'b1;
        tick();
        check_state("prio_mode", 8'h00, 1'b0, 1'b0);

        mode     = 1'b0;
        load     = 1'b1;
        load_val = 8'h20;
        tick();
        check_state("load_beats_en", 8'h20, 1'b0, 1'b0);

        load_val = 8'h05;
        en       = 1'b0;
        tick();
        check_state("ill_ring_05", 8'h05, 1'b0, 1'b1);
        load = 1'b0;
        en   = 1'b1;
        tick();
`ifdef RING_SELF_CORRECT_EN
        check_state("ill_ring_next", 8'h01, 1'b0, 1'b0);
`else
        check_state("ill_ring_next", 8'h0A, 1'b0, 1'b1);
`endif

        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h00;
        tick();
        check_state("ill_ring_zero", 8'h00, 1'b0, 1'b1);
        mode     = 1'b1;
        load_val = 8'h05;
        tick();
        check_state("ill_john_05", 8'h05, 1'b0, 1'b1);
        load_val = 8'hF0;
        tick();
        check_state("john_F0_legal", 8'hF0, 1'b0, 1'b0);
        load_val = 8'hFF;
        tick();
        check_state("john_FF_legal", 8'hFF, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
